// File: rtl/core_pkg.sv
// Shared types and encodings for the core sequencer and its decoder.
package core_pkg;

   localparam int unsigned ILEN = 32;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5,
      ST_TRAP    = 3'd6
   } state_t;

   // RV32I major opcodes (ir[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [ILEN-1:0] EBREAK_WORD = 32'h0010_0073;
   localparam logic [ILEN-1:0] NOP_WORD    = 32'h0000_0013;

   // Next-PC select
   localparam logic [1:0] PC_HOLD   = 2'b00;
   localparam logic [1:0] PC_PLUS4  = 2'b01;
   localparam logic [1:0] PC_BRANCH = 2'b10;
   localparam logic [1:0] PC_JALR   = 2'b11;

   // Register write-back source select
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   // Trap cause
   localparam logic [1:0] TRAP_NONE     = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
   localparam logic [1:0] TRAP_FETCH_TO = 2'b10;
   localparam logic [1:0] TRAP_DATA_TO  = 2'b11;

   typedef enum logic [3:0] {
      CLS_LUI     = 4'd0,
      CLS_AUIPC   = 4'd1,
      CLS_JAL     = 4'd2,
      CLS_JALR    = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_LOAD    = 4'd5,
      CLS_STORE   = 4'd6,
      CLS_OPIMM   = 4'd7,
      CLS_OP      = 4'd8,
      CLS_SYSTEM  = 4'd9,
      CLS_ILLEGAL = 4'd10
   } iclass_t;

   // Decoded view of the instruction register
   typedef struct packed {
      iclass_t cls;
      logic    legal;
      logic    is_ebreak;
      logic    rd_zero;
   } dec_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational classification of the instruction register.
module instr_class_decode
   import core_pkg::*;
(
   input  logic [ILEN-1:0] i_ir,
   output dec_t            o_dec
);

   // Map the major opcode to an instruction class; anything unknown is illegal
   always_comb begin
      o_dec           = '{cls: CLS_ILLEGAL, legal: 1'b0, is_ebreak: 1'b0, rd_zero: 1'b0};
      o_dec.rd_zero   = (i_ir[11:7] == 5'd0);
      o_dec.is_ebreak = (i_ir == EBREAK_WORD);
      o_dec.legal     = 1'b1;
      case (i_ir[6:0])
         OPC_LUI:    o_dec.cls = CLS_LUI;
         OPC_AUIPC:  o_dec.cls = CLS_AUIPC;
         OPC_JAL:    o_dec.cls = CLS_JAL;
         OPC_JALR:   o_dec.cls = CLS_JALR;
         OPC_BRANCH: o_dec.cls = CLS_BRANCH;
         OPC_LOAD:   o_dec.cls = CLS_LOAD;
         OPC_STORE:  o_dec.cls = CLS_STORE;
         OPC_OPIMM:  o_dec.cls = CLS_OPIMM;
         OPC_OP:     o_dec.cls = CLS_OP;
         OPC_SYSTEM: o_dec.cls = CLS_SYSTEM;
         default: begin
            o_dec.cls   = CLS_ILLEGAL;
            o_dec.legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch / decode / execute / mem / write-back.
module core_sequencer
   import core_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  mem_rdata,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic [XLEN-1:0]  ir,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic [1:0]       pc_sel,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             alu_b_imm,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
   localparam logic TIMEOUT_EN = (TIMEOUT != 0);

   if (XLEN != 32) begin : g_xlen_check
      $error("core_sequencer: XLEN must be 32");
   end

   state_t             r_state;
   state_t             w_state_next;
   logic [XLEN-1:0]    r_ir;
   logic [CNT_W-1:0]   r_retired;
   logic               r_halted;
   logic               r_trap;
   logic [1:0]         r_trap_cause;
   logic [WAIT_W-1:0]  r_wait;

   dec_t               w_dec;
   logic               w_wait_expired;
   logic               w_uses_imm;
   logic               w_ir_load;
   logic               w_retire;
   logic               w_set_halt;
   logic               w_set_trap;
   logic [1:0]         w_cause;

   instr_class_decode u_decode (
      .i_ir  (r_ir),
      .o_dec (w_dec)
   );

   assign w_wait_expired = TIMEOUT_EN && (r_wait == WAIT_LIMIT);
   assign w_uses_imm     = (w_dec.cls == CLS_LOAD)  || (w_dec.cls == CLS_STORE) ||
                           (w_dec.cls == CLS_OPIMM) || (w_dec.cls == CLS_JALR);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_FETCH;
      else       r_state <= w_state_next;
   end

   // Next-state and control-strobe decode
   always_comb begin
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      pc_sel       = PC_HOLD;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      alu_b_imm    = 1'b0;
      w_ir_load    = 1'b0;
      w_retire     = 1'b0;
      w_set_halt   = 1'b0;
      w_set_trap   = 1'b0;
      w_cause      = TRAP_NONE;

      case (r_state)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               w_ir_load    = 1'b1;
               w_state_next = ST_DECODE;
            end else if (w_wait_expired) begin
               w_set_trap   = 1'b1;
               w_cause      = TRAP_FETCH_TO;
               w_state_next = ST_TRAP;
            end
         end

         ST_DECODE: begin
            if (!w_dec.legal) begin
               w_set_trap   = 1'b1;
               w_cause      = TRAP_ILLEGAL;
               w_state_next = ST_TRAP;
            end else if (w_dec.cls == CLS_SYSTEM) begin
               if (w_dec.is_ebreak) begin
                  w_set_halt   = 1'b1;
                  w_state_next = ST_HALT;
               end else begin
                  w_set_trap   = 1'b1;
                  w_cause      = TRAP_ILLEGAL;
                  w_state_next = ST_TRAP;
               end
            end else begin
               w_state_next = ST_EXECUTE;
            end
         end

         ST_EXECUTE: begin
            alu_b_imm = w_uses_imm;
            case (w_dec.cls)
               CLS_BRANCH: begin
                  pc_sel       = branch_taken ? PC_BRANCH : PC_PLUS4;
                  w_retire     = 1'b1;
                  w_state_next = ST_FETCH;
               end
               CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
               default:             w_state_next = ST_WB;
            endcase
         end

         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            alu_b_imm    = w_uses_imm;
            mem_we       = (w_dec.cls == CLS_STORE);
            if (mem_ready) begin
               if (w_dec.cls == CLS_STORE) begin
                  pc_sel       = PC_PLUS4;
                  w_retire     = 1'b1;
                  w_state_next = ST_FETCH;
               end else begin
                  w_state_next = ST_WB;
               end
            end else if (w_wait_expired) begin
               w_set_trap   = 1'b1;
               w_cause      = TRAP_DATA_TO;
               w_state_next = ST_TRAP;
            end
         end

         ST_WB: begin
            alu_b_imm = w_uses_imm;
            reg_we    = !w_dec.rd_zero;
            case (w_dec.cls)
               CLS_LOAD:          wb_sel = WB_MEM;
               CLS_LUI:           wb_sel = WB_IMM;
               CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
               default:           wb_sel = WB_ALU;
            endcase
            case (w_dec.cls)
               CLS_JAL:  pc_sel = PC_BRANCH;
               CLS_JALR: pc_sel = PC_JALR;
               default:  pc_sel = PC_PLUS4;
            endcase
            w_retire     = 1'b1;
            w_state_next = ST_FETCH;
         end

         ST_HALT: w_state_next = ST_HALT;
         ST_TRAP: w_state_next = ST_TRAP;
         default: w_state_next = ST_FETCH;
      endcase
   end

   // Instruction register, retired counter and sticky status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir         <= XLEN'(NOP_WORD);
         r_retired    <= '0;
         r_halted     <= 1'b0;
         r_trap       <= 1'b0;
         r_trap_cause <= TRAP_NONE;
      end else begin
         if (w_ir_load)  r_ir      <= mem_rdata;
         if (w_retire)   r_retired <= r_retired + CNT_W'(1);
         if (w_set_halt) r_halted  <= 1'b1;
         if (w_set_trap) begin
            r_trap       <= 1'b1;
            r_trap_cause <= w_cause;
         end
      end
   end

   // Memory wait counter: restarts on every state change, counts while waiting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait <= '0;
      end else if (w_state_next != r_state) begin
         r_wait <= '0;
      end else if ((r_state == ST_FETCH) || (r_state == ST_MEM)) begin
         r_wait <= r_wait + WAIT_W'(1);
      end
   end

   assign ir         = r_ir;
   assign retired    = r_retired;
   assign halted     = r_halted;
   assign trap       = r_trap;
   assign trap_cause = r_trap_cause;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer (CNT_W=4, TIMEOUT=4).
module tb_core_sequencer;

   localparam logic [31:0] W_ADDI   = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] W_LW     = 32'h0000_A103; // lw   x2,0(x1)
   localparam logic [31:0] W_SW     = 32'h0020_A223; // sw   x2,4(x1)
   localparam logic [31:0] W_BEQ    = 32'h0000_0463; // beq  x0,x0,+8
   localparam logic [31:0] W_JAL    = 32'h0080_00EF; // jal  x1,+8
   localparam logic [31:0] W_JALR   = 32'h0000_8067; // jalr x0,0(x1)
   localparam logic [31:0] W_LUI    = 32'h1234_52B7; // lui  x5,0x12345
   localparam logic [31:0] W_NOP    = 32'h0000_0013;
   localparam logic [31:0] W_EBREAK = 32'h0010_0073;
   localparam logic [31:0] W_BAD    = 32'hFFFF_FFFF;

   logic        clk;
   logic        reset;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        branch_taken;
   logic [31:0] ir;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic [1:0]  pc_sel;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        alu_b_imm;
   logic [3:0]  retired;
   logic        halted;
   logic        trap;
   logic [1:0]  trap_cause;

   int n_checks = 0;
   int n_errors = 0;

   core_sequencer #(.XLEN(32), .CNT_W(4), .TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .ir           (ir),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .pc_sel       (pc_sel),
      .reg_we       (reg_we),
      .wb_sel       (wb_sel),
      .alu_b_imm    (alu_b_imm),
      .retired      (retired),
      .halted       (halted),
      .trap         (trap),
      .trap_cause   (trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word in FETCH with zero wait; returns in DECODE
   task automatic fetch(input logic [31:0] w);
      mem_rdata = w;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   // Zero-wait instruction that goes through WB; checks WB strobes and retire count
   task automatic run_wb(input string tag, input logic [31:0] w, input logic exp_we,
                         input logic [1:0] exp_wb, input logic [1:0] exp_pc,
                         input logic [3:0] exp_ret);
      fetch(w);
      tick();
      tick();
      chk({tag, "_reg_we"}, 32'(reg_we), 32'(exp_we));
      chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(exp_wb));
      chk({tag, "_pc_sel"}, 32'(pc_sel), 32'(exp_pc));
      tick();
      chk({tag, "_retired"}, 32'(retired), 32'(exp_ret));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      mem_rdata    = '0;
      mem_ready    = 1'b0;
      branch_taken = 1'b0;
      tick();
      tick();
      chk("rst_ir",      ir, W_NOP);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_halted",  32'(halted), 32'd0);
      chk("rst_trap",    32'(trap), 32'd0);
      chk("rst_cause",   32'(trap_cause), 32'd0);
      chk("rst_reg_we",  32'(reg_we), 32'd0);
      reset = 1'b0;
      chk("first_req",      32'(mem_req), 32'd1);
      chk("first_addr_sel", 32'(mem_addr_sel), 32'd0);

      // ADDI x1,x0,5: WB on cycle 4, mem_ready held high throughout
      fetch(W_ADDI);
      mem_ready = 1'b1;
      chk("addi_ir",      ir, W_ADDI);
      chk("addi_dec_req", 32'(mem_req), 32'd0);
      tick();
      chk("addi_ex_reg_we", 32'(reg_we), 32'd0);
      tick();
      chk("addi_wb_reg_we",  32'(reg_we), 32'd1);
      chk("addi_wb_sel",     32'(wb_sel), 32'd0);
      chk("addi_wb_pc_sel",  32'(pc_sel), 32'd1);
      chk("addi_wb_retired", 32'(retired), 32'd0);
      mem_ready = 1'b0;
      tick();
      chk("addi_retired", 32'(retired), 32'd1);
      chk("addi_reg_we_off", 32'(reg_we), 32'd0);

      // LW with MEM held 3 cycles
      fetch(W_LW);
      tick();
      chk("lw_ex_alu_b_imm", 32'(alu_b_imm), 32'd1);
      chk("lw_ex_req",       32'(mem_req), 32'd0);
      tick();
      chk("lw_mem1_req",  32'(mem_req), 32'd1);
      chk("lw_mem1_addr", 32'(mem_addr_sel), 32'd1);
      chk("lw_mem1_we",   32'(mem_we), 32'd0);
      tick();
      chk("lw_mem2_req",  32'(mem_req), 32'd1);
      tick();
      chk("lw_mem3_req",  32'(mem_req), 32'd1);
      chk("lw_mem3_we",   32'(mem_we), 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("lw_wb_reg_we",  32'(reg_we), 32'd1);
      chk("lw_wb_sel",     32'(wb_sel), 32'd1);
      chk("lw_wb_retired", 32'(retired), 32'd1);
      tick();
      chk("lw_retired", 32'(retired), 32'd2);

      // BEQ taken then not taken: 3 cycles each
      fetch(W_BEQ);
      tick();
      branch_taken = 1'b1;
      #1;
      chk("beq_t_pc_sel", 32'(pc_sel), 32'd2);
      chk("beq_t_reg_we", 32'(reg_we), 32'd0);
      tick();
      branch_taken = 1'b0;
      chk("beq_t_next_fetch", 32'(mem_req), 32'd1);
      chk("beq_t_retired",    32'(retired), 32'd3);
      fetch(W_BEQ);
      tick();
      chk("beq_n_pc_sel", 32'(pc_sel), 32'd1);
      tick();
      chk("beq_n_retired", 32'(retired), 32'd4);

      // SW: 4 cycles, store strobe in MEM
      fetch(W_SW);
      tick();
      chk("sw_ex_alu_b_imm", 32'(alu_b_imm), 32'd1);
      tick();
      chk("sw_mem_we", 32'(mem_we), 32'd1);
      mem_ready = 1'b1;
      #1;
      chk("sw_mem_pc_sel", 32'(pc_sel), 32'd1);
      tick();
      mem_ready = 1'b0;
      chk("sw_retired", 32'(retired), 32'd5);
      chk("sw_we_off",  32'(mem_we), 32'd0);

      run_wb("jal",  W_JAL,  1'b1, 2'b10, 2'b10, 4'd6);
      run_wb("jalr", W_JALR, 1'b0, 2'b10, 2'b11, 4'd7);
      run_wb("lui",  W_LUI,  1'b1, 2'b11, 2'b01, 4'd8);

      // Fetch completes in the cycle the wait counter reaches the limit
      repeat (4) tick();
      chk("late_rdy_no_trap", 32'(trap), 32'd0);
      chk("late_rdy_req",     32'(mem_req), 32'd1);
      fetch(W_NOP);
      chk("late_rdy_dec_trap", 32'(trap), 32'd0);
      tick();
      tick();
      chk("late_rdy_reg_we", 32'(reg_we), 32'd0);
      tick();
      chk("late_rdy_retired", 32'(retired), 32'd9);

      // 4-bit retired counter wraps
      for (int i = 0; i < 6; i++) run_wb("nop", W_NOP, 1'b0, 2'b00, 2'b01, 4'(10 + i));
      run_wb("nop_wrap", W_NOP, 1'b0, 2'b00, 2'b01, 4'd0);

      // Reset in the middle of a store access
      fetch(W_SW);
      tick();
      tick();
      chk("rst_mid_we_before", 32'(mem_we), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_we",      32'(mem_we), 32'd0);
      chk("rst_mid_retired", 32'(retired), 32'd0);
      chk("rst_mid_reg_we",  32'(reg_we), 32'd0);
      tick();
      reset = 1'b0;

      // Fetch timeout
      repeat (4) tick();
      chk("fto_pre_trap", 32'(trap), 32'd0);
      tick();
      chk("fto_trap",   32'(trap), 32'd1);
      chk("fto_cause",  32'(trap_cause), 32'd2);
      chk("fto_req",    32'(mem_req), 32'd0);
      chk("fto_pc_sel", 32'(pc_sel), 32'd0);
      mem_ready = 1'b1;
      mem_rdata = W_ADDI;
      repeat (3) tick();
      mem_ready = 1'b0;
      chk("fto_stay_trap", 32'(trap), 32'd1);
      chk("fto_stay_req",  32'(mem_req), 32'd0);
      chk("fto_stay_ir",   ir, W_NOP);

      // Illegal opcode
      do_reset();
      fetch(W_BAD);
      chk("ill_dec_trap", 32'(trap), 32'd0);
      tick();
      chk("ill_trap",   32'(trap), 32'd1);
      chk("ill_cause",  32'(trap_cause), 32'd1);
      chk("ill_halted", 32'(halted), 32'd0);

      // EBREAK
      do_reset();
      fetch(W_EBREAK);
      tick();
      chk("ebrk_halted",  32'(halted), 32'd1);
      chk("ebrk_trap",    32'(trap), 32'd0);
      chk("ebrk_retired", 32'(retired), 32'd0);
      chk("ebrk_req",     32'(mem_req), 32'd0);
      tick();
      chk("ebrk_stay", 32'(halted), 32'd1);

      // Data timeout on a load
      do_reset();
      fetch(W_LW);
      tick();
      tick();
      repeat (4) tick();
      chk("dto_pre_trap", 32'(trap), 32'd0);
      chk("dto_pre_addr", 32'(mem_addr_sel), 32'd1);
      tick();
      chk("dto_trap",   32'(trap), 32'd1);
      chk("dto_cause",  32'(trap_cause), 32'd3);
      chk("dto_reg_we", 32'(reg_we), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
